// File: rtl/fp32_pkg.sv
// ----------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the FP32 arithmetic blocks (divider, multiplier).
//   EXP_BIAS    : IEEE 754 single-precision exponent bias
//   EXP_MAX     : all-ones exponent (inf / NaN)
//   QNAN        : canonical quiet-NaN pattern
//   fp32_t      : packed view of a single-precision word
//   div_state_t : divider control states
// ----------------------------------------------------------------------------
package fp32_pkg;

   localparam int          EXP_BIAS = 127;
   localparam logic [7:0]  EXP_MAX  = 8'hFF;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      DIVIDE = 3'd2,
      NORM   = 3'd3,
      DONE   = 3'd4
   } div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// ----------------------------------------------------------------------------
// fp32_classify
// Combinational operand classifier for single-precision values.
// Subnormals are treated as zero because the arithmetic blocks flush them.
//   value   in  32  operand
//   is_nan  out 1   exponent all ones, fraction nonzero
//   is_inf  out 1   exponent all ones, fraction zero
//   is_zero out 1   exponent zero (true zero or subnormal)
// ----------------------------------------------------------------------------
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] value,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero
);

   fp32_t f;
   logic  sign_unused;

   assign f           = value;
   // The sign plays no part in the class of a value.
   assign sign_unused = f.sign;

   assign is_nan  = (f.exp == EXP_MAX) && (f.frac != 23'h0);
   assign is_inf  = (f.exp == EXP_MAX) && (f.frac == 23'h0);
   assign is_zero = (f.exp == 8'h00);

endmodule

// File: rtl/fp32_divider.sv
// ----------------------------------------------------------------------------
// fp32_divider
// Iterative single-precision divider, quotient_o = a_i / b_i.
// Radix-2 restoring mantissa division (one bit per cycle), truncating
// rounding, subnormal inputs and results flushed to zero.
// Latency: done_o 2 cycles after acceptance for special operands,
// 28 cycles otherwise.
//   clk         in  1   clock
//   rst_n       in  1   asynchronous active-low reset
//   start_i     in  1   request; sampled only in IDLE
//   a_i, b_i    in  32  dividend / divisor, captured on acceptance
//   quotient_o  out 32  registered result
//   done_o      out 1   one-cycle completion pulse
//   busy_o      out 1   high from acceptance through the DONE cycle
//   nan_o, infinit_o, div_zero_o, overflow_o, underflow_o
//               out 1   result flags, at most one set per operation
// ----------------------------------------------------------------------------
module fp32_divider #(
   parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] quotient_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        nan_o,
   output logic        infinit_o,
   output logic        div_zero_o,
   output logic        overflow_o,
   output logic        underflow_o
);

   import fp32_pkg::*;

   // Quotient bits produced; fixed by the 24-bit significand plus one
   // extra bit for normalisation.
   localparam int         DIV_STEPS = 25;
   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   div_state_t        state_reg, state_next;
   fp32_t             a_reg, b_reg;
   logic [24:0]       rem_reg;
   logic [23:0]       div_reg;
   logic [24:0]       q_reg;
   logic [4:0]        cnt_reg;
   logic signed [9:0] exp_reg;

   logic a_nan, a_inf, a_zero;
   logic b_nan, b_inf, b_zero;
   logic sign;

   fp32_classify u_class_a (.value(a_reg), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
   fp32_classify u_class_b (.value(b_reg), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

   assign sign = a_reg.sign ^ b_reg.sign;

   // Special-operand resolution in priority order.
   logic        sp_hit, sp_nan, sp_inf, sp_dz;
   logic [31:0] sp_result;

   always_comb begin
      sp_hit    = 1'b1;
      sp_nan    = 1'b0;
      sp_inf    = 1'b0;
      sp_dz     = 1'b0;
      sp_result = {sign, 31'h0};
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_nan    = 1'b1;
         sp_result = QNAN;
      end else if (a_inf) begin
         sp_inf    = 1'b1;
         sp_result = {sign, EXP_MAX, 23'h0};
      end else if (b_zero) begin
         sp_dz     = 1'b1;
         sp_result = {sign, EXP_MAX, 23'h0};
      end else if (!(a_zero || b_inf)) begin
         sp_hit = 1'b0;
      end
   end

   // Restoring division step: the remainder is always below twice the
   // divisor, so the difference fits in 24 bits before the shift.
   logic        rem_ge;
   logic [24:0] rem_diff;

   assign rem_ge   = (rem_reg >= {1'b0, div_reg});
   assign rem_diff = rem_reg - {1'b0, div_reg};

   // Normalisation: q lies in [2^23, 2^25); drop the extra bit when the
   // mantissa ratio was >= 1, otherwise lower the exponent by one.
   logic signed [9:0] exp_norm;
   logic [22:0]       frac_norm;

   assign exp_norm  = q_reg[24] ? exp_reg : exp_reg - 10'sd1;
   assign frac_norm = q_reg[24] ? q_reg[23:1] : q_reg[22:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next = state_reg;
      done_o     = 1'b0;
      busy_o     = 1'b1;
      unique case (state_reg)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_next = CHECK;
         end
         CHECK:  state_next = sp_hit ? DONE : DIVIDE;
         DIVIDE: if (cnt_reg == 5'd0) state_next = NORM;
         NORM:   state_next = DONE;
         DONE: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy_o     = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg       <= '0;
         b_reg       <= '0;
         rem_reg     <= '0;
         div_reg     <= '0;
         q_reg       <= '0;
         cnt_reg     <= '0;
         exp_reg     <= '0;
         quotient_o  <= '0;
         nan_o       <= 1'b0;
         infinit_o   <= 1'b0;
         div_zero_o  <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (start_i) begin
                  a_reg       <= a_i;
                  b_reg       <= b_i;
                  quotient_o  <= '0;
                  nan_o       <= 1'b0;
                  infinit_o   <= 1'b0;
                  div_zero_o  <= 1'b0;
                  overflow_o  <= 1'b0;
                  underflow_o <= 1'b0;
               end
            end
            CHECK: begin
               if (sp_hit) begin
                  quotient_o <= sp_result;
                  nan_o      <= sp_nan;
                  infinit_o  <= sp_inf;
                  div_zero_o <= sp_dz;
               end
               exp_reg <= $signed({2'b00, a_reg.exp} - {2'b00, b_reg.exp} + 10'(EXP_BIAS));
               rem_reg <= {2'b01, a_reg.frac};
               div_reg <= {1'b1, b_reg.frac};
               q_reg   <= '0;
               cnt_reg <= LAST_STEP;
            end
            DIVIDE: begin
               if (rem_ge) begin
                  q_reg[cnt_reg] <= 1'b1;
                  rem_reg        <= {rem_diff[23:0], 1'b0};
               end else begin
                  rem_reg <= {rem_reg[23:0], 1'b0};
               end
               if (cnt_reg != 5'd0) cnt_reg <= cnt_reg - 5'd1;
            end
            NORM: begin
               if (exp_norm >= 10'sd255) begin
                  quotient_o <= {sign, EXP_MAX, 23'h0};
                  overflow_o <= 1'b1;
               end else if (exp_norm <= 10'sd0) begin
                  quotient_o  <= {sign, 31'h0};
                  underflow_o <= 1'b1;
               end else begin
                  quotient_o <= {sign, exp_norm[7:0], frac_norm};
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_divider.sv
// ----------------------------------------------------------------------------
// tb_fp32_divider
// Self-checking bench for fp32_divider: directed vectors with literal
// expectations, a back-to-back handshake run, a mid-operation reset and a
// random sweep of normal operands against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_fp32_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic [31:0] quotient_o;
   logic        done_o, busy_o, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] q;
      logic [4:0]  f;
      int          lat;
      int          acc;
   } exp_t;

   exp_t pend[$];

   fp32_divider dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
      .quotient_o(quotient_o), .done_o(done_o), .busy_o(busy_o),
      .nan_o(nan_o), .infinit_o(infinit_o), .div_zero_o(div_zero_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   assign flags = {nan_o, infinit_o, div_zero_o, overflow_o, underflow_o};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: the quotient value a/b truncated to 24 significant bits.
   // Returns {nan, inf, div_zero, overflow, underflow, result}.
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
      int     ea, eb, e;
      longint ma, mb, mant;
      logic   s, an, ai, az, bn, bi, bz;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      an = (ea == 255) && (a[22:0] != 23'h0);
      ai = (ea == 255) && (a[22:0] == 23'h0);
      az = (ea == 0);
      bn = (eb == 255) && (b[22:0] != 23'h0);
      bi = (eb == 255) && (b[22:0] == 23'h0);
      bz = (eb == 0);
      s  = a[31] ^ b[31];
      if (an || bn || (az && bz) || (ai && bi)) return {5'b10000, 32'h7FC00000};
      if (ai) return {5'b01000, s, 8'hFF, 23'h0};
      if (bz) return {5'b00100, s, 8'hFF, 23'h0};
      if (az || bi) return {5'b00000, s, 31'h0};
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      if (ma >= mb) begin
         mant = (ma << 23) / mb;
         e    = ea - eb + 127;
      end else begin
         mant = (ma << 24) / mb;
         e    = ea - eb + 126;
      end
      if (e >= 255) return {5'b00010, s, 8'hFF, 23'h0};
      if (e <= 0)   return {5'b00001, s, 31'h0};
      return {5'b00000, s, 8'(e), mant[22:0]};
   endfunction

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // Compare process: tracks accepted operations and checks every cycle.
   always @(negedge clk) begin : compare
      exp_t        e;
      logic [36:0] m;
      if (!rst_n) begin
         pend.delete();
      end else begin
         check("busy", busy_o, pend.size() != 0);
         if (done_o) begin
            if (pend.size() == 0) begin
               check("unexpected_done", done_o, 1'b0);
            end else begin
               e = pend.pop_front();
               check("quotient", quotient_o, e.q);
               check("flags", flags, e.f);
               check("latency", cyc - e.acc, e.lat);
            end
         end
         check("flags_exclusive", $countones(flags) <= 1, 1'b1);
         if (start_i && !busy_o) begin
            m     = model(a_i, b_i);
            e.q   = m[31:0];
            e.f   = m[36:32];
            e.lat = is_special(a_i, b_i) ? 2 : 28;
            e.acc = cyc;
            pend.push_back(e);
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
      int t0;
      bit got;
      @(posedge clk); #1;
      start_i = 1'b1;
      a_i     = a;
      b_i     = b;
      @(posedge clk); #1;
      t0      = cyc;
      start_i = 1'b0;
      a_i     = $urandom;
      b_i     = $urandom;
      got     = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (done_o) got = 1'b1;
      end
      lat = cyc - t0 + 1;
      check("done_seen", got, 1'b1);
   endtask

   localparam int NV = 9;
   logic [31:0] va [NV] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h7FC00001,
                            32'h00000000, 32'h7F000000, 32'h00800000, 32'h80800000};
   logic [31:0] vb [NV] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3F800000,
                            32'h00000000, 32'h3E800000, 32'h40000000, 32'h40000000};
   logic [31:0] vq [NV] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                            32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
   logic [4:0]  vf [NV] = '{5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b10000,
                            5'b10000, 5'b00010, 5'b00001, 5'b00001};
   int          vl [NV] = '{28, 28, 2, 2, 2, 2, 28, 28, 28};

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          lat, n, last;
      logic [31:0] b2b_q [3];
      logic [31:0] ra, rb;
      b2b_q = '{32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAA};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_quotient", quotient_o, 32'h0);
      check("reset_flags", flags, 5'h0);
      check("reset_done", done_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      rst_n = 1'b1;

      // Directed vectors: literal results, flags, latency, and hold after done
      for (int i = 0; i < NV; i++) begin
         check("model_pin", model(va[i], vb[i]), {vf[i], vq[i]});
         do_op(va[i], vb[i], lat);
         check("lit_latency", lat, vl[i]);
         check("lit_quotient", quotient_o, vq[i]);
         check("lit_flags", flags, vf[i]);
         repeat (2) @(negedge clk);
         check("hold_quotient", quotient_o, vq[i]);
         check("hold_flags", flags, vf[i]);
         $display("op %0d: %h / %h -> %h flags=%b latency=%0d", i, va[i], vb[i], quotient_o, flags, lat);
      end

      // start_i held high: 29-cycle cadence, operand change while busy
      // only affects the next acceptance.
      @(posedge clk); #1;
      start_i = 1'b1;
      a_i     = 32'h40C00000;
      b_i     = 32'h40000000;
      n       = 0;
      last    = 0;
      for (int k = 0; k < 200 && n < 3; k++) begin
         @(negedge clk);
         if (k == 10) begin
            a_i = 32'h3F800000;
            b_i = 32'h40400000;
         end
         if (done_o) begin
            check("b2b_quotient", quotient_o, b2b_q[n]);
            if (n > 0) check("b2b_period", cyc - last, 29);
            $display("b2b %0d: quotient=%h at cycle %0d", n, quotient_o, cyc);
            last = cyc;
            n++;
         end
      end
      start_i = 1'b0;
      check("b2b_count", n, 3);

      // Reset in the middle of DIVIDE
      @(posedge clk); #1;
      @(posedge clk); #1;
      start_i = 1'b1;
      a_i     = 32'h40C00000;
      b_i     = 32'h40000000;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_quotient", quotient_o, 32'h0);
      check("midrst_flags", flags, 5'h0);
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_done", done_o, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_no_done", done_o, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check("abandoned_no_done", done_o, 1'b0);
      end
      do_op(32'h3F800000, 32'h40400000, lat);
      check("post_rst_quotient", quotient_o, 32'h3EAAAAAA);
      check("post_rst_latency", lat, 28);
      $display("post-reset op: quotient=%h latency=%0d", quotient_o, lat);

      // Random normal operands; the compare process checks each result.
      for (int i = 0; i < 1500; i++) begin
         if (i % 2 == 0) begin
            ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         end else begin
            ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         end
         do_op(ra, rb, lat);
         $display("rand %0d: %h / %h -> %h flags=%b", i, ra, rb, quotient_o, flags);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", pend.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
